systolic_tile_ctrl: RTL
=======================

// Module: systolic_tile_ctrl
// PURPOSE
//  Next-generation systolic-array controller. Issues A/B beat-address requests over valid/ready,
//  tracks buffer write addresses and credits (no buffer overrun), and raises array_start once a
//  configurable fill threshold is met. Sits between config regs, memory read fifos, operand buffers, array.
// PARAMETERS
//  BUS_WIDTH_BYTES       32  bytes per memory beat (A and B)
//  DATA_WIDTH_BYTES      1   bytes per matrix element
//  BUFFER_ADDRESS_WIDTH  10  operand buffer depth = 2**BUFFER_ADDRESS_WIDTH beats (per matrix)
//  DIM_WIDTH             16  width of m, n, p
//  ADDR_WIDTH            16  memory byte-address width
// PORTS
//  clk             in   1     clock
//  reset           in   1     synchronous, active-high reset
//  start_i         in   1     start pulse; m,n,p,bases,mode_i sampled when accepted
//  m, n, p         in   DIM_WIDTH  A is m x n, B is n x p
//  base_addr_a/b   in   ADDR_WIDTH  byte base addresses
//  mode_i          in   1     0 = start at half buffer, 1 = start only when matrix fully buffered
//  a_req_addr      out  ADDR_WIDTH  A beat byte address; b_req_addr likewise
//  a_req_valid     out  1     A request valid; b_req_valid likewise
//  a_req_ready     in   1     A fifo accepts; b_req_ready likewise
//  a_valid_data    in   1     one A beat written to buffer this cycle; b_valid_data likewise
//  a_buffer_addr   out  BUFFER_ADDRESS_WIDTH  A write address; b_buffer_addr likewise
//  a_consume       in   1     array freed one A beat; b_consume likewise
//  array_start     out  1     level, array may run
//  data_done       in   1     array finished job
//  busy / done     out  1     job active / 1-cycle completion pulse
//  err_cfg         out  1     1-cycle pulse, start rejected
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, FSM IDLE; reset mid-job aborts, no done.
//  - Beats: EPB = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES; a_beats = ceil(m*n/EPB), b_beats = ceil(n*p/EPB);
//    32-bit products/counters. Addr = base + idx*BUS_WIDTH_BYTES, mod 2**ADDR_WIDTH.
//  - FSM IDLE -> FETCH -> RUN -> IDLE. IDLE: start_i with m|n|p==0, or mode_i=1 with a_beats or
//    b_beats > depth -> err_cfg next cycle, stay IDLE. Else FETCH, busy=1, first req_valid next cycle.
//  - Request: valid held, addr stable until ready; idx++ on valid&ready; stops at beats.
//    Credit: valid only while issued-consumed < depth; consume and handshake same cycle = net 0.
//  - Buffer addr: +1 per valid_data, wraps mod depth; valid_data outside FETCH/RUN ignored.
//  - Threshold per matrix: mode0 rcvd >= min(beats, depth/2); mode1 rcvd == beats. Both met ->
//    RUN, array_start=1 next cycle, held until data_done.
//  - RUN: fetch continues until all beats issued. data_done -> array_start=0, busy=0, done=1 next cycle, IDLE.
//  - start_i while busy ignored; data_done in IDLE/FETCH ignored. start_i and data_done same cycle
//    in RUN: job ends, new start ignored.
// STRUCTURE
//  - Package systolic_ctrl_pkg: state_e {IDLE,FETCH,RUN}, CNT_WIDTH=32, ceil-div function.
//  - Sub-module stream_req_gen (x2, A and B): beat count, addr gen, valid/ready, credit counter,
//    rcvd counter, buffer addr, threshold flag. Top: FSM, cfg checks, array_start/done.
// TESTING (BUS_WIDTH_BYTES=32, DATA_WIDTH_BYTES=1, BUFFER_ADDRESS_WIDTH=4 unless noted)
//  1. m=4,n=8,p=4,mode0, base_a=0x100, base_b=0x200, ready=1 -> one req each at 0x100/0x200;
//     one valid_data each -> array_start next cycle; data_done -> done 1 cycle, busy 0.
//  2. a_req_ready low 5 cycles mid-stream -> a_req_valid held, a_req_addr constant; then advances +32.
//  3. m=16,n=64 (32 beats), no consume -> exactly 16 A handshakes then valid=0; 1 a_consume ->
//     exactly one more.
//  4. mode0, 32 beats each -> array_start after 8th A and 8th B valid_data; mode1 same dims ->
//     err_cfg pulse, no requests, busy 0.
//  5. n=0 -> err_cfg one cycle, IDLE; start_i during RUN ignored; data_done in IDLE no effect.
//  6. reset during RUN -> all outputs 0 next edge, no done; new start_i then runs scenario 1 correctly.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic tile controller.
// Provides the FSM state type, counter width and a ceiling divide.
package systolic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN
  } state_e;

  localparam int CNT_WIDTH = 32;

  function automatic logic [CNT_WIDTH-1:0] ceil_div(
    input logic [CNT_WIDTH-1:0] num,
    input logic [CNT_WIDTH-1:0] den
  );
    logic [CNT_WIDTH-1:0] q;
    q = num / den;
    if ((num % den) != '0)
      q = q + CNT_WIDTH'(1);
    return q;
  endfunction

endpackage

// File: rtl/stream_req_gen.sv
// Per-matrix request stream: beat addresses over valid/ready, buffer credit,
// received-beat count, buffer write address and fill-threshold flag.
// Ports: load/active from the FSM, req_* to the memory fifo, valid_data and
// consume from the buffer side, thr_met back to the FSM.
module stream_req_gen
  import systolic_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH_BYTES      = 32,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int ADDR_WIDTH           = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load,
  input  logic                            active,
  input  logic                            mode,
  input  logic [CNT_WIDTH-1:0]            beats,
  input  logic [ADDR_WIDTH-1:0]           base,
  input  logic                            req_ready,
  input  logic                            valid_data,
  input  logic                            consume,
  output logic [ADDR_WIDTH-1:0]           req_addr,
  output logic                            req_valid,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_addr,
  output logic                            thr_met
);

  localparam logic [CNT_WIDTH-1:0] DEPTH =
    CNT_WIDTH'(1) << BUFFER_ADDRESS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] HALF = DEPTH >> 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(BUS_WIDTH_BYTES);

  logic [CNT_WIDTH-1:0] total;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] used;
  logic [CNT_WIDTH-1:0] rcvd;
  logic [CNT_WIDTH-1:0] level;
  logic [CNT_WIDTH-1:0] rcvd_nxt;
  logic                 hs;
  logic                 take;
  logic                 free;

  assign req_valid = active && (issued < total) && (used < DEPTH);
  assign hs        = req_valid && req_ready;
  assign take      = active && valid_data;
  assign free      = consume && (used != '0);
  assign rcvd_nxt  = take ? rcvd + CNT_WIDTH'(1) : rcvd;
  // Include this cycle's beat so the FSM can react on the same edge.
  assign thr_met   = rcvd_nxt >= level;

  always_ff @(posedge clk) begin
    if (reset) begin
      total       <= '0;
      issued      <= '0;
      used        <= '0;
      rcvd        <= '0;
      level       <= '0;
      req_addr    <= '0;
      buffer_addr <= '0;
    end else if (load) begin
      total       <= beats;
      issued      <= '0;
      used        <= '0;
      rcvd        <= '0;
      req_addr    <= base;
      buffer_addr <= '0;
      if (mode)
        level <= beats;
      else
        level <= (beats < HALF) ? beats : HALF;
    end else begin
      if (hs) begin
        issued   <= issued + CNT_WIDTH'(1);
        req_addr <= req_addr + STRIDE;
      end
      // Handshake and consume in one cycle cancel out.
      if (hs && !free)
        used <= used + CNT_WIDTH'(1);
      else if (!hs && free)
        used <= used - CNT_WIDTH'(1);
      if (take) begin
        rcvd        <= rcvd_nxt;
        buffer_addr <= buffer_addr +
          BUFFER_ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Systolic tile controller: job FSM, config checks, array_start/done.
// Ports: job config + start_i, A/B request and buffer streams, array handshake.
module systolic_tile_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH_BYTES      = 32,
  parameter int DATA_WIDTH_BYTES     = 1,
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int DIM_WIDTH            = 16,
  parameter int ADDR_WIDTH           = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic [DIM_WIDTH-1:0]            m,
  input  logic [DIM_WIDTH-1:0]            n,
  input  logic [DIM_WIDTH-1:0]            p,
  input  logic [ADDR_WIDTH-1:0]           base_addr_a,
  input  logic [ADDR_WIDTH-1:0]           base_addr_b,
  input  logic                            mode_i,
  output logic [ADDR_WIDTH-1:0]           a_req_addr,
  output logic                            a_req_valid,
  input  logic                            a_req_ready,
  output logic [ADDR_WIDTH-1:0]           b_req_addr,
  output logic                            b_req_valid,
  input  logic                            b_req_ready,
  input  logic                            a_valid_data,
  input  logic                            b_valid_data,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] a_buffer_addr,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] b_buffer_addr,
  input  logic                            a_consume,
  input  logic                            b_consume,
  output logic                            array_start,
  input  logic                            data_done,
  output logic                            busy,
  output logic                            done,
  output logic                            err_cfg
);

  localparam int EPB = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam logic [CNT_WIDTH-1:0] DEPTH =
    CNT_WIDTH'(1) << BUFFER_ADDRESS_WIDTH;

  state_e               state;
  logic [CNT_WIDTH-1:0] a_beats;
  logic [CNT_WIDTH-1:0] b_beats;
  logic                 cfg_bad;
  logic                 load;
  logic                 active;
  logic                 a_thr;
  logic                 b_thr;

  assign a_beats = ceil_div(CNT_WIDTH'(m) * CNT_WIDTH'(n),
                            CNT_WIDTH'(EPB));
  assign b_beats = ceil_div(CNT_WIDTH'(n) * CNT_WIDTH'(p),
                            CNT_WIDTH'(EPB));
  assign cfg_bad = (m == '0) || (n == '0) || (p == '0) ||
                   (mode_i && ((a_beats > DEPTH) ||
                               (b_beats > DEPTH)));
  assign load    = (state == IDLE) && start_i && !cfg_bad;
  assign active  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      array_start <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              err_cfg <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (a_thr && b_thr) begin
            state       <= RUN;
            array_start <= 1'b1;
          end
        end
        RUN: begin
          if (data_done) begin
            state       <= IDLE;
            array_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_req_gen #(
    .BUS_WIDTH_BYTES     (BUS_WIDTH_BYTES),
    .BUFFER_ADDRESS_WIDTH(BUFFER_ADDRESS_WIDTH),
    .ADDR_WIDTH          (ADDR_WIDTH)
  ) u_a (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .active     (active),
    .mode       (mode_i),
    .beats      (a_beats),
    .base       (base_addr_a),
    .req_ready  (a_req_ready),
    .valid_data (a_valid_data),
    .consume    (a_consume),
    .req_addr   (a_req_addr),
    .req_valid  (a_req_valid),
    .buffer_addr(a_buffer_addr),
    .thr_met    (a_thr)
  );

  stream_req_gen #(
    .BUS_WIDTH_BYTES     (BUS_WIDTH_BYTES),
    .BUFFER_ADDRESS_WIDTH(BUFFER_ADDRESS_WIDTH),
    .ADDR_WIDTH          (ADDR_WIDTH)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .active     (active),
    .mode       (mode_i),
    .beats      (b_beats),
    .base       (base_addr_b),
    .req_ready  (b_req_ready),
    .valid_data (b_valid_data),
    .consume    (b_consume),
    .req_addr   (b_req_addr),
    .req_valid  (b_req_valid),
    .buffer_addr(b_buffer_addr),
    .thr_met    (b_thr)
  );

endmodule
